// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - slice-pipelined adder with per-stage valid/ready flow control
// Define PIPE_ADDER_SUB_EN to add the sub input (sum = a - b when sub=1).
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int S    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ld;

`ifdef PIPE_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // A stage loads when empty or when its content moves on; for an occupied
  // stage that reduces to "the stage above can load".
  always_comb begin
    ld       = '0;
    ld[LAST] = ~v_q[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      ld[k] = ~v_q[k] | ld[k+1];
    end
  end

  assign in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // x holds finished sum slices below slice k and untouched A slices above.
    logic [WIDTH-1:0] x_i, y_i, x_nx, x_r, y_r;
    logic             c_i, v_i, o_nx;
    logic             v_r, c_r, o_r;
    logic [S:0]       slice;
    logic             unused_bits;

    if (k == 0) begin : g_src
      assign x_i = a;
      assign y_i = b_eff;
      assign c_i = cin_eff;
      assign v_i = in_valid;
    end else begin : g_src
      assign x_i = g_st[k-1].x_r;
      assign y_i = g_st[k-1].y_r;
      assign c_i = g_st[k-1].c_r;
      assign v_i = g_st[k-1].v_r;
    end

    assign slice = {1'b0, x_i[k*S +: S]} + {1'b0, y_i[k*S +: S]} + {{S{1'b0}}, c_i};

    always_comb begin
      x_nx            = x_i;
      x_nx[k*S +: S]  = slice[S-1:0];
    end

    // Only the top slice sees both operand sign bits next to the sum sign bit.
    assign o_nx = (k == LAST) && (x_i[WIDTH-1] == y_i[WIDTH-1]) &&
                  (slice[S-1] != x_i[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        x_r <= '0;
        y_r <= '0;
        c_r <= 1'b0;
        o_r <= 1'b0;
      end else if (ld[k]) begin
        v_r <= v_i;
        if (v_i) begin
          x_r <= x_nx;
          y_r <= y_i;
          c_r <= slice[S];
          o_r <= o_nx;
        end
      end
    end

    assign v_q[k]      = v_r;
    assign unused_bits = ^{y_r, o_r};
  end

  assign out_valid = g_st[LAST].v_r;
  assign sum       = g_st[LAST].x_r;
  assign cout      = g_st[LAST].c_r;
  assign ovf       = g_st[LAST].o_r;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - randomized scoreboard bench for pipe_adder
// Define PIPE_ADDER_SUB_EN to also exercise the sub input.
module tb_pipe_adder;

  localparam int W  = 16;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_chk = 0;
  int   n_fail = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    longint ua, ub, sa, sb, us, ss;
    res_t   r;
    ua = ta;
    ub = tb;
    sa = $signed(ta);
    sb = $signed(tb);
    if (ts) begin
      us = ua + 65536 - ub;
      ss = sa - sb;
    end else begin
      us = ua + ub + tc;
      ss = sa + sb + tc;
    end
    r.s = us[15:0];
    r.c = (us >= 65536);
    r.o = (ss > 32767) || (ss < -32768);
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check("sb_sum", sum, r.s);
          check("sb_cout", cout, r.c);
          check("sb_ovf", ovf, r.o);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    int t;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    sub = ts;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("send_wait", t < 200, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int t;
    send(ta, tb, tc, ts);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("latency", t, ST - 1);
    check("dir_sum", sum, es);
    check("dir_cout", cout, ec);
    check("dir_ovf", ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc, cnt, t;
    logic took;
    logic [W-1:0] held;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef PIPE_ADDER_SUB_EN
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`endif
    idle(4);

    // Streaming: eight back-to-back, results on eight consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'b0);
        in_valid = 1'b0;
      end
      begin
        t = 0;
        while (!out_valid && t < 30) begin
          @(posedge clk); #1;
          t++;
        end
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", out_valid, 1);
          @(posedge clk); #1;
        end
        check("stream_end", out_valid, 0);
      end
    join
    idle(4);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: only STAGES transactions fit while the output stalls.
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    a = pick();
    b = pick();
    cin = 1'($urandom);
    for (int i = 0; i < 10; i++) begin
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        a = pick();
        b = pick();
        cin = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, ST);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_front", sum, exp_q[0].s);
    held = sum;
    idle(3);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_sum", sum, held);
    in_valid = 1'b1;
    a = 16'hA5A5;
    b = 16'h5A5B;
    out_ready = 1'b1;
    #1;
    check("full_passthru", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(8);
    check("bp_drained", exp_q.size(), 0);

    // Reset with three transactions in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h0F0F, 16'h1010, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0);
    in_valid = 1'b0;
    idle(2);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("stale_after_rst", cnt, 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick();
      b = pick();
      cin = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES, giving slice width S = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: an operand set is presented.
REQ-006 SHALL have port in_ready, output, 1: the block accepts an operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A, unsigned or two's complement.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in to bit 0.
REQ-010 SHALL have port out_valid, output, 1: a result is presented.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH: result bits.
REQ-013 SHALL have port cout, output, 1: carry out of the MSB.
REQ-014 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-015 SHALL split the WIDTH-bit addition into STAGES slices of S bits; pipeline stage k SHALL add slice k (bits k*S .. k*S+S-1) using the carry registered from stage k-1 (stage 0 uses cin).
REQ-016 SHALL carry unprocessed upper operand slices forward through the stage registers, and completed lower sum slices likewise, so each transaction stays aligned.
REQ-017 SHALL have a latency of exactly STAGES cycles from an accepted input (in_valid & in_ready at edge N) to out_valid high after edge N+STAGES-1, when out_ready stays high.
REQ-018 SHALL sustain a throughput of one transaction per cycle when out_ready is held high.
REQ-019 SHALL keep one valid bit per stage; stage k SHALL load when stage k is empty or stage k is advancing into stage k+1 (the output is consumed for the last stage).
REQ-020 SHALL set in_ready = ~valid[0] | stage 0 advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL collapse bubbles: empty stages SHALL fill while downstream is stalled, so up to STAGES transactions are buffered.
REQ-023 SHALL return results in acceptance order, with no loss or duplication.
REQ-024 SHALL compute cout as the carry out of bit WIDTH-1, and ovf as (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]), where B' is the effective second operand.
REQ-025 SHALL accept a new input and deliver an output in the same cycle when full and out_ready=1.

Reset
REQ-026 SHALL, while rst_n=0, immediately clear all stage valid bits and all data and carry registers; out_valid, sum, cout and ovf SHALL read 0.
REQ-027 SHALL drive in_ready to 1 from the first edge after rst_n deasserts.
REQ-028 SHALL discard in-flight transactions when reset asserts mid-operation, and no stale result SHALL appear afterwards.

Configuration
REQ-029 SHALL, when macro PIPE_ADDER_SUB_EN is defined, add input port sub (1 bit, sampled with a) that travels with its transaction; when sub=1, B' = ~b and the stage-0 carry-in is forced to 1 (cin ignored), giving sum = a - b.
REQ-030 SHALL, when PIPE_ADDER_SUB_EN is undefined, have no sub port and set B' = b.

Verification
REQ-031 SHALL cover basic add: WIDTH=16, STAGES=4, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL cover the full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
REQ-033 SHALL cover streaming: 8 back-to-back transactions with out_ready=1 -> 8 in-order correct results on 8 consecutive cycles.
REQ-034 SHALL cover backpressure: out_ready=0 for 10 cycles with in_valid=1 -> exactly 4 accepted, then in_ready=0; the output is held stable; all results are correct after release.
REQ-035 SHALL cover reset mid-stream: rst_n pulsed low with 3 transactions in flight -> out_valid=0 immediately; no old results appear after release.
REQ-036 SHALL cover subtraction (PIPE_ADDER_SUB_EN defined): a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1; and a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
